serial_word_tx: RTL and testbench

Serial word transmitter: the transmit end of the lab's single-wire serial link, producing the bit stream that the receiver-side `Top` samples on its `inp` line. It accepts a parallel `DATA_W`-bit word on a one-cycle `data_ready` strobe and shifts it out as a framed serial stream: start bit, data LSB first, optional parity, stop bit. Each bit is held for a fixed `BIT_CYCLES` clock periods. It replaces hand-timed stimulus on the serial line, both in benches and on the board.

---
 rtl/serial_pkg.sv | 18 +
 rtl/serial_word_tx_bit_timer.sv | 36 +++
 rtl/serial_word_tx.sv | 161 ++++++++++++++++
 tb/tb_serial_word_tx.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared types and constants for the single-wire serial link.
// Used by both the transmitter and the receiver side.
package serial_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } serial_state_e;

    localparam int SERIAL_DATA_W_DEF     = 16;
    localparam int SERIAL_BIT_CYCLES_DEF = 220;

    localparam logic SERIAL_IDLE_LVL = 1'b1;

endpackage

// File: rtl/serial_word_tx_bit_timer.sv
// Per-bit cycle counter for the serial transmitter.
// Pulses bit_end on the last cycle of every serial bit period.
module bit_timer
    import serial_pkg::*;
#(
    parameter int BIT_CYCLES = SERIAL_BIT_CYCLES_DEF
) (
    input  logic CLOCK_50,
    input  logic rst,
    input  logic clear,
    output logic bit_end
);

    localparam int CW = $clog2(BIT_CYCLES);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign bit_end = (cnt_q == CW'(BIT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || bit_end) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_word_tx.sv
// Framed serial word transmitter: start, data LSB first, stop.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit before stop.
module serial_word_tx
    import serial_pkg::*;
#(
    parameter int DATA_W     = SERIAL_DATA_W_DEF,
    parameter int BIT_CYCLES = SERIAL_BIT_CYCLES_DEF
) (
    input  logic              CLOCK_50,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_ready,
    output logic              busy,
    output logic              done,
    output logic              outp
);

    localparam int IW = $clog2(DATA_W + 1);

    serial_state_e state_q, state_d;

    logic [DATA_W-1:0] shift_q, shift_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              outp_q, outp_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
`ifdef SERIAL_TX_PARITY_EN
    logic              par_q, par_d;
`endif

    logic bit_end;
    logic last_bit;

    assign last_bit = (idx_q == IW'(DATA_W - 1));

    bit_timer #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_timer (
        .CLOCK_50(CLOCK_50),
        .rst     (rst),
        .clear   (state_q == S_IDLE),
        .bit_end (bit_end)
    );

    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            outp_q  <= SERIAL_IDLE_LVL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            outp_q  <= outp_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (data_ready) state_d = S_START;
            end
            S_START: begin
                if (bit_end) state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_end && last_bit) begin
`ifdef SERIAL_TX_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (bit_end) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // outp is registered, so each bit's level is set on the edge that enters it
    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        outp_d  = outp_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (data_ready) begin
                    shift_d = data_in;
                    idx_d   = '0;
                    outp_d  = 1'b0;
                    busy_d  = 1'b1;
`ifdef SERIAL_TX_PARITY_EN
                    par_d   = ^data_in;
`endif
                end
            end
            S_START: begin
                if (bit_end) outp_d = shift_q[0];
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 1'b1;
                    outp_d  = shift_d[0];
                    if (last_bit) begin
`ifdef SERIAL_TX_PARITY_EN
                        outp_d = par_q;
`else
                        outp_d = SERIAL_IDLE_LVL;
`endif
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) outp_d = SERIAL_IDLE_LVL;
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    outp_d = SERIAL_IDLE_LVL;
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
            end
            default: begin
                outp_d = SERIAL_IDLE_LVL;
                busy_d = 1'b0;
            end
        endcase
    end

    assign outp = outp_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_serial_word_tx.sv
// Directed self-checking bench for serial_word_tx.
// Honours SERIAL_TX_PARITY_EN to match the DUT build.
module tb_serial_word_tx;

    localparam int DW = 16;
    localparam int BC = 220;
`ifdef SERIAL_TX_PARITY_EN
    localparam int NB = DW + 3;
`else
    localparam int NB = DW + 2;
`endif
    localparam int FRAME = NB * BC;

    logic          clk;
    logic          rst;
    logic [DW-1:0] data_in;
    logic          data_ready;
    logic          busy;
    logic          done;
    logic          outp;

    int checks   = 0;
    int failures = 0;

    serial_word_tx #(
        .DATA_W    (DW),
        .BIT_CYCLES(BC)
    ) dut (
        .CLOCK_50  (clk),
        .rst       (rst),
        .data_in   (data_in),
        .data_ready(data_ready),
        .busy      (busy),
        .done      (done),
        .outp      (outp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [DW-1:0] w, input int b);
        if (b == 0) return 1'b0;
        if (b <= DW) return w[b-1];
`ifdef SERIAL_TX_PARITY_EN
        if (b == DW + 1) return ^w;
`endif
        return 1'b1;
    endfunction

    // Caller has set data_in=w and data_ready=1 at a negedge before the
    // accept edge. Sample n is taken at the negedge after edge n.
    task automatic frame(input logic [DW-1:0] w, input bit hold,
                         input logic [DW-1:0] next_w, input bit poke);
        int busy_cnt = 0;
        int done_cnt = 0;
        for (int n = 0; n <= FRAME; n++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) done_cnt++;
            if (n == 0) begin
                chk("start_outp", {31'b0, outp}, 32'd0);
                chk("start_busy", {31'b0, busy}, 32'd1);
                data_in = DW'($urandom);
                if (!hold) data_ready = 1'b0;
            end
            if (poke && n == 3 * BC + 10) begin
                data_ready = 1'b1;
                data_in    = 16'hFFFF;
            end
            if (poke && n == 3 * BC + 11) data_ready = 1'b0;
            if (n % BC == BC / 2 && n < FRAME) begin
                chk($sformatf("bit%0d_%h", n / BC, w), {31'b0, outp},
                    {31'b0, exp_bit(w, n / BC)});
            end
            if (n == FRAME) begin
                chk("end_done", {31'b0, done}, 32'd1);
                chk("end_busy", {31'b0, busy}, 32'd0);
                chk("idle_gap_outp", {31'b0, outp}, 32'd1);
                if (hold) data_in = next_w;
            end
        end
        chk("busy_len", busy_cnt, FRAME);
        chk("done_cnt", done_cnt, 1);
    endtask

    initial begin
        int bad;
        rst        = 1'b0;
        data_in    = '0;
        data_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_outp", {31'b0, outp}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        rst = 1'b1;

        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (outp !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        chk("idle_quiet", bad, 0);

        data_in    = 16'hA5C3;
        data_ready = 1'b1;
        frame(16'hA5C3, 1'b0, '0, 1'b0);

        repeat (5) @(negedge clk);
        data_in    = 16'h00F0;
        data_ready = 1'b1;
        frame(16'h00F0, 1'b0, '0, 1'b1);

        repeat (5) @(negedge clk);
        data_in    = 16'h0001;
        data_ready = 1'b1;
        frame(16'h0001, 1'b1, 16'h8000, 1'b0);
        frame(16'h8000, 1'b0, '0, 1'b0);

        repeat (5) @(negedge clk);
        data_in    = 16'h3C3C;
        data_ready = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            if (n == 0) data_ready = 1'b0;
        end
        chk("pre_rst_busy", {31'b0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_outp", {31'b0, outp}, 32'd1);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || outp !== 1'b1) bad++;
        end
        rst = 1'b1;
        for (int i = 0; i < 3 * BC; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk("abort_no_done", bad, 0);

        data_in    = 16'hA5C3;
        data_ready = 1'b1;
        frame(16'hA5C3, 1'b0, '0, 1'b0);

`ifdef SERIAL_TX_PARITY_EN
        repeat (5) @(negedge clk);
        data_in    = 16'h0007;
        data_ready = 1'b1;
        frame(16'h0007, 1'b0, '0, 1'b0);
        repeat (5) @(negedge clk);
        data_in    = 16'h0003;
        data_ready = 1'b1;
        frame(16'h0003, 1'b0, '0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
